bomb_fuse_controller: RTL
=========================

BOMB_FUSE_CONTROLLER -- requirements
Module: bomb_fuse_controller

Interface
REQ-001 Parameter N, default 50000000, clock cycles per second.
REQ-002 Parameter FUSE_SEC, default 3, fuse length in seconds, integer >= 1.
REQ-003 Parameter BLAST_SEC, default 1, blast window length in seconds, integer >= 1.
REQ-004 Parameter COOLDOWN_SEC, default 2, re-arm lockout in seconds, integer >= 1; every SEC*N product SHALL be <= 2^28-1.
REQ-005 clk  in  1  single system clock; all logic on posedge.
REQ-006 resetn  in  1  synchronous, active-low reset.
REQ-007 placeBomb  in  1  player bomb key, level, synchronous to clk.
REQ-008 detonate  in  1  early-detonation key, level.
REQ-009 playerPosX, playerPosY  in  6 each  player grid cell; valid range 0..62.
REQ-010 bombPosX, bombPosY  out  6 each  live bomb cell; 6'h3F (off-grid sentinel) when no bomb is live.
REQ-011 bombArmed  out  1  high while fuse is burning.
REQ-012 bombExploded  out  1  one-cycle pulse at detonation.
REQ-013 blastActive  out  1  high for the whole blast window.
REQ-014 ready  out  1  high when a new bomb may be placed.

Function
REQ-015 The FSM SHALL have states IDLE, ARMED, BLAST, COOLDOWN; all outputs SHALL be registered.
REQ-016 Placement SHALL trigger only on a rising edge of placeBomb: placeBomb=1 this cycle and the previous-sample register=0.
REQ-017 IDLE + placement edge at edge t: from t+1, state=ARMED, bombArmed=1, ready=0, bombPos = playerPos sampled at t; counter=FUSE_SEC*N-1.
REQ-018 ARMED: counter SHALL decrement by 1 per cycle; bombArmed SHALL stay high exactly FUSE_SEC*N cycles, then state=BLAST.
REQ-019 ARMED + detonate=1: next cycle state=BLAST, regardless of counter value.
REQ-020 Entering BLAST: bombExploded=1 for exactly the first BLAST cycle; bombArmed=0; blastActive=1; counter=BLAST_SEC*N-1.
REQ-021 BLAST: bombPos SHALL hold the latched cell; blastActive SHALL stay high exactly BLAST_SEC*N cycles, then state=COOLDOWN.
REQ-022 COOLDOWN: bombPos=6'h3F, blastActive=0, ready=0, counter=COOLDOWN_SEC*N-1; after exactly COOLDOWN_SEC*N cycles, state=IDLE and ready=1.
REQ-023 The 28-bit counter SHALL never wrap; a reload SHALL occur only on a state entry.
REQ-024 A placement edge in ARMED, BLAST or COOLDOWN SHALL be ignored and not queued; a key still held on return to IDLE SHALL NOT place a bomb.
REQ-025 detonate SHALL be ignored in IDLE, BLAST and COOLDOWN.
REQ-026 detonate=1 in the same cycle the fuse counter reaches 0 SHALL produce exactly one BLAST entry and one bombExploded pulse.
REQ-027 playerPos changes after placement SHALL NOT affect bombPos.
REQ-028 In IDLE: bombArmed=0, blastActive=0, bombExploded=0, ready=1, bombPos=6'h3F.

Reset
REQ-029 resetn=0 at a clock edge SHALL force state=IDLE, counter=0, all outputs to IDLE values (REQ-028), and the placeBomb previous-sample register=1.
REQ-030 Reset in any state, including mid-fuse or mid-blast, SHALL abort without a bombExploded pulse.
REQ-031 A placeBomb held high through reset release SHALL NOT place a bomb until it is released and pressed again.

Verification (N=4, FUSE_SEC=3, BLAST_SEC=1, COOLDOWN_SEC=2)
REQ-032 Place at (10,20), no detonate: bombArmed 12 cycles; bombExploded 1 cycle; blastActive 4 cycles with bombPos=(10,20); 8 cooldown cycles with bombPos=3F; then ready=1.
REQ-033 Place at (5,5), detonate on armed cycle 3: BLAST entered on the next cycle; one bombExploded pulse; blastActive 4 cycles.
REQ-034 placeBomb held high continuously for 40 cycles: exactly one bomb placed; no second placement after return to IDLE.
REQ-035 Place at (0,0), then move player to (7,7) during ARMED: bombPos stays (0,0) through BLAST.
REQ-036 resetn=0 on armed cycle 6: next cycle IDLE, bombPos=3F, ready=1; bombExploded never asserts.
REQ-037 detonate=1 on the cycle the fuse counter hits 0: exactly one bombExploded pulse; BLAST length 4.

Source files
------------

// File: rtl/bomb_fuse_controller.sv
// Single-bomb fuse controller: place on key edge, burn fuse, blast window, cooldown lockout.
// Every output is registered and derived from the next-state decision.
module bomb_fuse_controller #(
    parameter int unsigned N            = 50000000,
    parameter int unsigned FUSE_SEC     = 3,
    parameter int unsigned BLAST_SEC    = 1,
    parameter int unsigned COOLDOWN_SEC = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       placeBomb,
    input  logic       detonate,
    input  logic [5:0] playerPosX,
    input  logic [5:0] playerPosY,
    output logic [5:0] bombPosX,
    output logic [5:0] bombPosY,
    output logic       bombArmed,
    output logic       bombExploded,
    output logic       blastActive,
    output logic       ready
);

    localparam int unsigned CNT_W = 28;
    localparam int unsigned POS_W = 6;

    localparam logic [CNT_W-1:0] FUSE_LOAD  = CNT_W'(FUSE_SEC * N - 1);
    localparam logic [CNT_W-1:0] BLAST_LOAD = CNT_W'(BLAST_SEC * N - 1);
    localparam logic [CNT_W-1:0] COOL_LOAD  = CNT_W'(COOLDOWN_SEC * N - 1);
    localparam logic [POS_W-1:0] NO_POS     = POS_W'(6'h3F);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_BLAST = 2'd2,
        S_COOL  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_place_q;
    logic [POS_W-1:0] pos_x_q, pos_x_d;
    logic [POS_W-1:0] pos_y_q, pos_y_d;
    logic             armed_q, armed_d;
    logic             exploded_q, exploded_d;
    logic             blast_q, blast_d;
    logic             ready_q, ready_d;
    logic             place_edge;

    // Previous-sample register resets high so a key held through reset is not an edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            prev_place_q <= 1'b1;
            pos_x_q      <= NO_POS;
            pos_y_q      <= NO_POS;
            armed_q      <= 1'b0;
            exploded_q   <= 1'b0;
            blast_q      <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            prev_place_q <= placeBomb;
            pos_x_q      <= pos_x_d;
            pos_y_q      <= pos_y_d;
            armed_q      <= armed_d;
            exploded_q   <= exploded_d;
            blast_q      <= blast_d;
            ready_q      <= ready_d;
        end
    end

    assign place_edge = placeBomb & ~prev_place_q;

    // Counter reloads only on state entry and never decrements past zero.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        exploded_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (place_edge) begin
                    state_d = S_ARMED;
                    cnt_d   = FUSE_LOAD;
                    pos_x_d = playerPosX;
                    pos_y_d = playerPosY;
                end
            end
            S_ARMED: begin
                if (detonate || (cnt_q == '0)) begin
                    state_d    = S_BLAST;
                    cnt_d      = BLAST_LOAD;
                    exploded_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_BLAST: begin
                if (cnt_q == '0) begin
                    state_d = S_COOL;
                    cnt_d   = COOL_LOAD;
                    pos_x_d = NO_POS;
                    pos_y_d = NO_POS;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_COOL: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                pos_x_d = NO_POS;
                pos_y_d = NO_POS;
            end
        endcase

        armed_d = (state_d == S_ARMED);
        blast_d = (state_d == S_BLAST);
        ready_d = (state_d == S_IDLE);
    end

    assign bombPosX     = pos_x_q;
    assign bombPosY     = pos_y_q;
    assign bombArmed    = armed_q;
    assign bombExploded = exploded_q;
    assign blastActive  = blast_q;
    assign ready        = ready_q;

endmodule
